// File: rtl/reaction_timer_core.sv
// Reaction-timer game controller: random pre-go delay, millisecond reaction count,
// false-start / timeout detection and best-score tracking in one FSM.
module reaction_timer_core #(
    parameter int                TICK_DIV     = 50000,
    parameter int                LFSR_W       = 12,
    parameter logic [LFSR_W-1:0] LFSR_TAPS    = 12'hE08,
    parameter int                MIN_DELAY_MS = 1000,
    parameter int                CNT_W        = 24,
    parameter int                MAX_MS       = 9999,
    parameter int                LED_W        = 10
) (
    input  logic             clk50M,
    input  logic             rst,
    input  logic             onoff,
    input  logic             start,
    input  logic             stop,
    output logic [CNT_W-1:0] ms_count,
    output logic [CNT_W-1:0] best,
    output logic [CNT_W-1:0] dly_ms,
    output logic [LED_W-1:0] led,
    output logic             go,
    output logic             false_start,
    output logic             timeout,
    output logic             result_valid,
    output logic [2:0]       state
);

    localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_IDLE   = 3'd1,
        S_WAIT   = 3'd2,
        S_GO     = 3'd3,
        S_RESULT = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t            cur_state, nxt_state;
    logic [LFSR_W-1:0] lfsr;
    logic              fb;
    logic [PS_W-1:0]   prescaler, prescaler_nxt;
    logic              tick;
    logic [CNT_W-1:0]  dly_cnt, dly_cnt_nxt;
    logic [CNT_W-1:0]  ms_count_nxt, best_nxt, dly_ms_nxt, new_dly;
    logic              go_nxt, false_start_nxt, timeout_nxt, result_valid_nxt;

    assign fb      = ^(lfsr & LFSR_TAPS);
    assign tick    = (prescaler == PS_W'(TICK_DIV - 1));
    assign new_dly = CNT_W'(MIN_DELAY_MS) + CNT_W'(lfsr);
    assign state   = cur_state;

    always_comb begin
        nxt_state        = cur_state;
        prescaler_nxt    = tick ? '0 : prescaler + 1'b1;
        dly_cnt_nxt      = dly_cnt;
        ms_count_nxt     = ms_count;
        best_nxt         = best;
        dly_ms_nxt       = dly_ms;
        go_nxt           = go;
        false_start_nxt  = false_start;
        timeout_nxt      = timeout;
        result_valid_nxt = 1'b0;

        if (!onoff) begin
            nxt_state       = S_OFF;
            ms_count_nxt    = '0;
            dly_ms_nxt      = '0;
            go_nxt          = 1'b0;
            false_start_nxt = 1'b0;
            timeout_nxt     = 1'b0;
        end else begin
            case (cur_state)
                S_OFF: nxt_state = S_IDLE;

                // A start from any resting state begins a fresh round; stop is ignored here.
                S_IDLE, S_RESULT, S_FAULT: begin
                    if (start) begin
                        nxt_state       = S_WAIT;
                        dly_ms_nxt      = new_dly;
                        dly_cnt_nxt     = new_dly;
                        ms_count_nxt    = '0;
                        prescaler_nxt   = '0;
                        timeout_nxt     = 1'b0;
                        false_start_nxt = 1'b0;
                    end
                end

                S_WAIT: begin
                    if (stop) begin
                        nxt_state       = S_FAULT;
                        false_start_nxt = 1'b1;
                        ms_count_nxt    = '0;
                    end else if (tick) begin
                        dly_cnt_nxt = dly_cnt - 1'b1;
                        if (dly_cnt <= CNT_W'(1)) begin
                            nxt_state     = S_GO;
                            go_nxt        = 1'b1;
                            ms_count_nxt  = '0;
                            prescaler_nxt = '0;
                        end
                    end
                end

                // Stop freezes the count before any coincident tick is applied.
                S_GO: begin
                    if (stop) begin
                        nxt_state        = S_RESULT;
                        go_nxt           = 1'b0;
                        result_valid_nxt = 1'b1;
                        if (ms_count < best) best_nxt = ms_count;
                    end else if (tick) begin
                        if (ms_count >= CNT_W'(MAX_MS - 1)) begin
                            nxt_state    = S_RESULT;
                            ms_count_nxt = CNT_W'(MAX_MS);
                            go_nxt       = 1'b0;
                            timeout_nxt  = 1'b1;
                        end else begin
                            ms_count_nxt = ms_count + 1'b1;
                        end
                    end
                end

                default: nxt_state = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            cur_state    <= S_OFF;
            lfsr         <= LFSR_W'(1);
            prescaler    <= '0;
            dly_cnt      <= '0;
            ms_count     <= '0;
            best         <= '1;
            dly_ms       <= '0;
            led          <= '0;
            go           <= 1'b0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            cur_state    <= nxt_state;
            lfsr         <= {lfsr[LFSR_W-2:0], fb};
            prescaler    <= prescaler_nxt;
            dly_cnt      <= dly_cnt_nxt;
            ms_count     <= ms_count_nxt;
            best         <= best_nxt;
            dly_ms       <= dly_ms_nxt;
            led          <= {LED_W{go_nxt}};
            go           <= go_nxt;
            false_start  <= false_start_nxt;
            timeout      <= timeout_nxt;
            result_valid <= result_valid_nxt;
        end
    end

endmodule
